// File: rtl/apb_i2c_cmd_sequencer.sv
// apb_i2c_cmd_sequencer
// Turns a host command stream into APB master transfers towards the APB-to-I2C
// bridge. Commands are queued in a small FIFO. Each command becomes exactly one
// APB transfer (SETUP then ACCESS). The sequencer waits for PREADY, and if the
// wait runs too long it aborts the transfer. It returns one response per command.
//
// Optional feature (macro SEQ_RX_GATE_EN): a READ_RX command at the FIFO head is
// held in IDLE while INT_RX=1 (bridge RX empty). Commands behind it stay in order.
// When the macro is undefined, INT_RX is ignored.
module apb_i2c_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,   // power of two, 2..16
    parameter int WAIT_MAX   = 16   // ACCESS cycles without PREADY before abort
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    // host command stream
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [31:0]                   cmd_data,
    // host response stream
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_err,
    output logic                          rsp_timeout,
    // APB master port
    output logic                          PSELx,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [31:0]                   PADDR,
    output logic [31:0]                   PWDATA,
    input  logic [31:0]                   PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR,
    // bridge status
    input  logic                          INT_RX,
    // status
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(WAIT_MAX) + 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_MAX - 1);
    localparam logic [1:0]    OP_READ_RX = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [1:0]    fifo_op  [FIFO_DEPTH];
    logic [31:0]   fifo_dat [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          full, push, pop;
    logic [1:0]    head_op;
    logic [31:0]   head_data;
    logic          head_blocked;

    assign full      = (count == LEVEL_FULL);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head_op   = fifo_op[rd_ptr];
    assign head_data = fifo_dat[rd_ptr];

`ifdef SEQ_RX_GATE_EN
    // A read of an empty RX buffer is pointless, so hold it at the head.
    assign head_blocked = (head_op == OP_READ_RX) && INT_RX;
`else
    assign head_blocked = 1'b0;
    logic unused_int_rx;
    assign unused_int_rx = INT_RX;
`endif

    // Command storage: write the slot at wr_ptr on each accepted command.
    // NOTE: the storage array is deliberately not reset. Occupancy lives in count, so stale slots are never read.
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_dat[wr_ptr] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy. Push and pop in the same cycle keep the level.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    logic [1:0]    op_q;
    logic [31:0]   data_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   rsp_data_q;
    logic          rsp_err_q;
    logic          rsp_to_q;
    logic          wait_expired;

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // State register. Reset drops straight to IDLE, which clears the APB outputs at once.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and pop decision. Popping happens only on IDLE->SETUP.
    // NOTE: defaults are assigned first so no path leaves a signal unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && !head_blocked) begin
                    pop       = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (PREADY || wait_expired) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the popped command and count ACCESS cycles.
    // Capture the completion status; PREADY wins over the timeout.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            op_q       <= 2'b00;
            data_q     <= '0;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else if (pop) begin
            op_q     <= head_op;
            data_q   <= head_data;
            wait_cnt <= '0;
        end else if (state == S_ACCESS) begin
            wait_cnt <= wait_cnt + CW'(1);
            if (PREADY) begin
                rsp_data_q <= (op_q == OP_READ_RX) ? PRDATA : 32'd0;
                rsp_err_q  <= PSLVERR;
                rsp_to_q   <= 1'b0;
            end else if (wait_expired) begin
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
                rsp_to_q   <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. These are decoded from the state register only, so the bus is quiet outside a transfer.
    // ------------------------------------------------------------------
    logic is_write;

    assign is_write    = (op_q != OP_READ_RX);
    assign PSELx       = (state == S_SETUP) || (state == S_ACCESS);
    assign PENABLE     = (state == S_ACCESS);
    assign PWRITE      = PSELx && is_write;
    assign PADDR       = PSELx ? {28'd0, op_q, 2'b00} : 32'd0;
    assign PWDATA      = (PSELx && is_write) ? data_q : 32'd0;

    assign rsp_valid   = (state == S_RESP);
    assign rsp_data    = rsp_valid ? rsp_data_q : 32'd0;
    assign rsp_err     = rsp_valid && rsp_err_q;
    assign rsp_timeout = rsp_valid && rsp_to_q;

    assign fifo_level  = count;
    assign busy        = (state != S_IDLE) || (count != '0);

    // ------------------------------------------------------------------
    // Protocol invariants
    // ------------------------------------------------------------------
    a_enable_needs_select: assert property (@(posedge PCLK) disable iff (PRESET)
        PENABLE |-> PSELx);

    a_access_stable: assert property (@(posedge PCLK) disable iff (PRESET)
        (state == S_ACCESS && $past(state) == S_ACCESS)
            |-> ($stable(PADDR) && $stable(PWRITE) && $stable(PWDATA)));

    a_level_bound: assert property (@(posedge PCLK) disable iff (PRESET)
        count <= LEVEL_FULL);

endmodule

// File: tb/tb_apb_i2c_cmd_sequencer.sv
// tb_apb_i2c_cmd_sequencer
// Randomized host and APB slave around apb_i2c_cmd_sequencer. A transaction-level
// reference model predicts the bus pattern of every transfer, the response
// contents, FIFO occupancy and busy. It works from queues and from the cycle
// count since each SETUP.
module tb_apb_i2c_cmd_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int WAIT_MAX   = 16;
    localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_CFG = 2'b10, OP_TO = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] data;
    } cmd_t;

    logic PCLK = 1'b0;
    logic PRESET;
    logic cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [31:0] cmd_data;
    logic rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic rsp_err, rsp_timeout;
    logic PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic PREADY, PSLVERR, INT_RX;
    logic busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    apb_i2c_cmd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_RX(INT_RX),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 PCLK = ~PCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    cmd_t send_q[$];          // host commands not yet accepted
    cmd_t exp_q[$];           // accepted, response not yet taken (head may be in flight)
    bit   in_flight;          // head of exp_q has been issued on the bus
    int   cyc;                // cycles since its SETUP (0 = SETUP)
    int   w;                  // slave wait: PREADY in access cycle index w
    int   n_acc;              // predicted number of ACCESS cycles
    logic [31:0] rd_val, e_data;
    logic err_val, e_err, e_to;
    bit   expect_setup;

    // Knobs
    int   force_w      = -1;
    bit   force_rd_en  = 1'b0;
    logic [31:0] force_rd = '0;
    int   force_err    = -1;
    int   int_rx_force = 0;
    int   rsp_pct      = 100;
    int   host_pct     = 100;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_wait();
        int r;
        if (force_w >= 0) return force_w;
        r = $urandom_range(0, 9);
        case (r)
            0:       return WAIT_MAX + $urandom_range(0, 5);
            1:       return WAIT_MAX - 1;
            2:       return WAIT_MAX - 2;
            default: return $urandom_range(0, 3);
        endcase
    endfunction

    task automatic queue_cmd(input logic [1:0] op, input logic [31:0] data);
        cmd_t c;
        c.op = op;
        c.data = data;
        send_q.push_back(c);
    endtask

    task automatic reset_model();
        exp_q.delete();
        send_q.delete();
        in_flight    = 1'b0;
        expect_setup = 1'b0;
        cyc          = 0;
    endtask

    // One clock: observe on the falling edge, compare, then drive the next inputs.
    task automatic step();
        bit setup_seen, exp_sel, exp_en, exp_rv, gated;
        int level;
        cmd_t cur;
        @(negedge PCLK);
        setup_seen = PSELx && !PENABLE;
        check("setup_issue", setup_seen, expect_setup);
        if (setup_seen && !in_flight && exp_q.size() != 0) begin
            in_flight = 1'b1;
            cyc       = 0;
            w         = pick_wait();
            rd_val    = force_rd_en ? force_rd : $urandom();
            err_val   = (force_err >= 0) ? force_err[0] : 1'($urandom_range(0, 1));
            n_acc     = (w < WAIT_MAX) ? w + 1 : WAIT_MAX;
            if (w < WAIT_MAX) begin
                e_data = (exp_q[0].op == OP_RD) ? rd_val : 32'd0;
                e_err  = err_val;
                e_to   = 1'b0;
            end else begin
                e_data = 32'd0;
                e_err  = 1'b0;
                e_to   = 1'b1;
            end
        end else if (in_flight) begin
            cyc++;
        end

        exp_sel = in_flight && (cyc <= n_acc);
        exp_en  = in_flight && (cyc >= 1) && (cyc <= n_acc);
        exp_rv  = in_flight && (cyc > n_acc);
        check("PSELx", PSELx, exp_sel);
        check("PENABLE", PENABLE, exp_en);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_sel) begin
            cur = exp_q[0];
            check("PADDR", PADDR, {28'd0, cur.op, 2'b00});
            check("PWRITE", PWRITE, cur.op != OP_RD);
            check("PWDATA", PWDATA, (cur.op != OP_RD) ? cur.data : 32'd0);
        end
        if (exp_rv) begin
            check("rsp_data", rsp_data, e_data);
            check("rsp_err", rsp_err, e_err);
            check("rsp_timeout", rsp_timeout, e_to);
        end
        level = exp_q.size() - int'(in_flight);
        check("fifo_level", fifo_level, level);
        check("cmd_ready", cmd_ready, level != FIFO_DEPTH);
        check("busy", busy, exp_q.size() != 0);

        // APB slave
        if (exp_en && (cyc - 1 == w)) begin
            PREADY  = 1'b1;
            PRDATA  = rd_val;
            PSLVERR = err_val;
        end else begin
            PREADY  = exp_en ? 1'b0 : 1'($urandom_range(0, 1));
            PRDATA  = $urandom();
            PSLVERR = 1'($urandom_range(0, 1));
        end
        rsp_ready = ($urandom_range(0, 99) < rsp_pct);
        INT_RX    = (int_rx_force >= 0) ? int_rx_force[0] : 1'($urandom_range(0, 1));

        gated = 1'b0;
`ifdef SEQ_RX_GATE_EN
        if (level > 0 && exp_q[int'(in_flight)].op == OP_RD && INT_RX) gated = 1'b1;
`endif
        expect_setup = !in_flight && (level > 0) && !gated;

        if (exp_rv && rsp_ready) begin
            void'(exp_q.pop_front());
            in_flight = 1'b0;
        end

        // Host
        cmd_valid = (send_q.size() != 0) && ($urandom_range(0, 99) < host_pct);
        if (cmd_valid) begin
            cmd_op   = send_q[0].op;
            cmd_data = send_q[0].data;
        end else begin
            cmd_op   = 2'($urandom_range(0, 3));
            cmd_data = $urandom();
        end
        if (cmd_valid && cmd_ready) exp_q.push_back(send_q.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((send_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", (send_q.size() == 0) && (exp_q.size() == 0), 1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard;
        bit reached;
        cmd_t c;

        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; INT_RX = 1'b0;
        reset_model();
        #1;
        check("reset_outputs_zero",
              {PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_data, rsp_err,
               rsp_timeout, busy, fifo_level}, '0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        @(negedge PCLK);
        PRESET = 1'b0;

        // Reset in the middle of an ACCESS phase of CFG 0x0000_1234
        force_w = 1000;
        queue_cmd(OP_CFG, 32'h0000_1234);
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            step();
            reached = in_flight && (cyc >= 2) && (cyc <= n_acc);
        end
        check("mid_access_reached", reached, 1'b1);
        #2;
        PRESET = 1'b1;
        cmd_valid = 1'b0;
        #1;
        check("async_reset_psel", PSELx, 1'b0);
        check("async_reset_penable", PENABLE, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b0;
        reset_model();
        #1;
        check("post_reset_level", fifo_level, 0);
        check("post_reset_rsp_valid", rsp_valid, 1'b0);
        check("post_reset_cmd_ready", cmd_ready, 1'b1);

        // WRITE_TX with PREADY in the first access cycle
        force_w = 0; force_err = 0; rsp_pct = 100; host_pct = 100;
        queue_cmd(OP_WR, 32'hA5A5_0001);
        drain(50);

        // READ_RX: PREADY in the third access cycle, with a slave error
        force_w = 2; force_rd_en = 1'b1; force_rd = 32'h0000_00C3; force_err = 1;
        queue_cmd(OP_RD, 32'hDEAD_BEEF);
        drain(50);
        force_rd_en = 1'b0; force_err = -1;

        // TIMEOUT register write with PREADY never asserted
        force_w = 1000;
        queue_cmd(OP_TO, 32'h0000_3FFF);
        drain(60);

        // Five back-to-back commands while the host holds off responses
        force_w = 0; rsp_pct = 0;
        queue_cmd(OP_CFG, 32'h1111_0000);
        queue_cmd(OP_TO,  32'h2222_0000);
        queue_cmd(OP_WR,  32'h3333_0000);
        queue_cmd(OP_WR,  32'h4444_0000);
        queue_cmd(OP_RD,  32'h5555_0000);
        repeat (15) step();
        check("full_level", fifo_level, FIFO_DEPTH);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_rsp_held", rsp_valid, 1'b1);
        rsp_pct = 100;
        drain(80);

        // READ_RX queued while the bridge reports RX empty, then released
        force_w = -1; int_rx_force = 1;
        queue_cmd(OP_RD, 32'h0);
        queue_cmd(OP_WR, 32'h0BAD_F00D);
        repeat (12) step();
        int_rx_force = 0;
        drain(120);

        // Randomized traffic
        force_w = -1; int_rx_force = -1; rsp_pct = 70; host_pct = 70;
        sent = 0; guard = 0;
        while (sent < 300 && guard < 20000) begin
            if (send_q.size() < 3 && $urandom_range(0, 2) == 0) begin
                c.op = 2'($urandom_range(0, 3));
                c.data = $urandom();
                send_q.push_back(c);
                sent++;
            end
            step();
            guard++;
        end
        check("random_all_sent", sent >= 300, 1'b1);
        int_rx_force = 0;
        drain(4000);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_i2c_cmd_sequencer.md
Name: apb_i2c_cmd_sequencer

Overview:
- APB master sequencer that drives the APB-to-I2C bridge from a simple host command stream.
- Queues host commands in a small FIFO, turns each one into one APB transfer, waits for PREADY, and returns one response per command.
- Opcode-to-register map:
  - WRITE_TX (addr 0)
  - READ_RX (addr 4)
  - CFG (addr 8)
  - TIMEOUT (addr 12)
- Sits between the host/CPU glue and the bridge's APB slave port.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16)
- WAIT_MAX, 16, maximum access-phase cycles without PREADY before the transfer is aborted

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous reset, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_op  in  2  00 WRITE_TX, 01 READ_RX, 10 CFG, 11 TIMEOUT
- cmd_data  in  32  write data (ignored for READ_RX)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  32  read data (READ_RX), else 0
- rsp_err  out  1  PSLVERR sampled at completion
- rsp_timeout  out  1  transfer aborted after WAIT_MAX cycles
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error
- INT_RX  in  1  bridge RX-empty indication
- busy  out  1  state not IDLE, or FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async on PRESET high):
  - FIFO empty; state IDLE.
  - All outputs 0, except cmd_ready=1.
  - APB outputs drop in the same cycle reset asserts, including mid-transfer. The in-flight command and any pending response are discarded.
- FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid&&cmd_ready. Pop on the IDLE->SETUP transition.
  - Push and pop in the same cycle are allowed when not full; level is unchanged.
  - No bypass: a pushed command enters SETUP no earlier than the cycle after the push edge.
- Opcode mapping:
  - PADDR = {op,2'b00} zero-extended.
  - PWRITE = (op != 01).
  - PWDATA = cmd_data for writes, 0 for reads.
- FSM: IDLE, SETUP, ACCESS, RESP.
  - IDLE: FIFO non-empty -> pop, latch op/data, go to SETUP.
  - SETUP (exactly 1 cycle): PSELx=1, PENABLE=0, address/direction/data valid. Next state ACCESS.
  - ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
    - Wait counter starts at 0 and increments each ACCESS cycle.
    - PREADY=1 -> capture PRDATA (reads only; writes give 0) and PSLVERR; rsp_timeout=0; go to RESP.
    - Counter reaches WAIT_MAX-1 with PREADY=0 -> rsp_timeout=1, rsp_err=0, rsp_data=0; go to RESP.
    - PREADY and timeout in the same cycle: PREADY wins.
  - RESP: PSELx=PENABLE=0; rsp_valid=1 with fields stable until rsp_ready. On handshake go to IDLE. Next SETUP occurs at earliest 1 cycle later.
- Minimum command-to-command spacing is 4 cycles with PREADY in the first access cycle and rsp_ready tied high.
- PSELx is never high in IDLE or RESP. PENABLE is never high without PSELx.
- busy = (state != IDLE) || (fifo_level != 0).

Optional Feature:
- Macro SEQ_RX_GATE_EN.
- Defined: a READ_RX command at the FIFO head is not popped while INT_RX=1 (RX empty). It waits in IDLE with no timeout. Commands behind it keep their order and are not reordered around it. When INT_RX falls, the pop happens on the next IDLE cycle.
- Not defined: INT_RX is ignored and READ_RX is issued immediately.

Test Plan:
- Reset mid-ACCESS of CFG 0x0000_1234 -> PSELx/PENABLE go 0 asynchronously; after release fifo_level=0, rsp_valid=0, cmd_ready=1.
- Push WRITE_TX 0xA5A5_0001, PREADY=1 in the first access cycle -> SETUP shows PADDR=0, PWRITE=1, PENABLE=0; next cycle PENABLE=1; response rsp_data=0, rsp_err=0, rsp_timeout=0.
- Push READ_RX, PRDATA=0x0000_00C3, PREADY after 3 access cycles, PSLVERR=1 -> PADDR=4, PWRITE=0, PWDATA=0; rsp_data=0xC3, rsp_err=1; PADDR stable across all 3 access cycles.
- Push TIMEOUT 0x0000_3FFF, PREADY held 0 -> exactly 16 ACCESS cycles, then rsp_timeout=1, rsp_data=0; PADDR=12 throughout.
- Push 5 commands back-to-back with rsp_ready=0 and PREADY=1 -> cmd_ready falls once the FIFO is full. First command completes and holds in RESP; FIFO holds the remaining 4 (fifo_level=4, cmd_ready=0). Releasing rsp_ready drains all in order CFG, TIMEOUT, WRITE_TX, WRITE_TX, READ_RX.
- With SEQ_RX_GATE_EN: READ_RX queued while INT_RX=1 for 10 cycles -> PSELx stays 0; INT_RX falls -> SETUP within 2 cycles.
